reorder_buffer: RTL

//  In-order retirement buffer of the Tomasulo core; the consumer of RS/LSB results.

---
 rtl/reorder_buffer_pkg.sv | 6 +
 rtl/rob_query.sv | 34 +++
 rtl/reorder_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizes for the reorder buffer and its lookup helper.
package reorder_buffer_pkg;
    localparam int ROB_ADDR_W = 3;   // default index width, 8 entries
    localparam int REG_W      = 5;   // architectural register number
    localparam int DATA_W     = 32;  // result / PC width
endpackage

// File: rtl/rob_query.sv
// Operand lookup into the reorder buffer with same-cycle CDB bypass.
module rob_query
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_ADDR = ROB_ADDR_W
) (
    input  logic [ROB_ADDR-1:0]                   idx,
    input  logic                                  rs_valid,
    input  logic [ROB_ADDR-1:0]                   rs_robindex,
    input  logic [DATA_W-1:0]                     rs_value,
    input  logic                                  lsb_valid,
    input  logic [ROB_ADDR-1:0]                   lsb_robindex,
    input  logic [DATA_W-1:0]                     lsb_value,
    input  logic [2**ROB_ADDR-1:0]                ready_vec,
    input  logic [2**ROB_ADDR-1:0][DATA_W-1:0]    value_vec,
    output logic                                  ready,
    output logic [DATA_W-1:0]                     value
);

    // A result arriving on the CDB this cycle wins over the stored copy.
    always_comb begin
        ready = ready_vec[idx];
        value = value_vec[idx];
        if (lsb_valid && lsb_robindex == idx) begin
            ready = 1'b1;
            value = lsb_value;
        end
        if (rs_valid && rs_robindex == idx) begin
            ready = 1'b1;
            value = rs_value;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate on issue, capture CDB writebacks,
// retire the head to the register file, flush on a mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_ADDR = ROB_ADDR_W
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic [REG_W-1:0]     issue_rd,
    input  logic                 issue_is_branch,
    input  logic                 issue_pred_tkn,
    input  logic [DATA_W-1:0]    issue_alt_pc,
    output logic                 rob_full,
    output logic [ROB_ADDR-1:0]  rob_tail,
    input  logic                 rs_valid,
    input  logic [ROB_ADDR-1:0]  rs_robindex,
    input  logic [DATA_W-1:0]    rs_value,
    input  logic                 lsb_valid,
    input  logic [ROB_ADDR-1:0]  lsb_robindex,
    input  logic [DATA_W-1:0]    lsb_value,
    input  logic [ROB_ADDR-1:0]  qj_idx,
    input  logic [ROB_ADDR-1:0]  qk_idx,
    output logic                 qj_ready,
    output logic                 qk_ready,
    output logic [DATA_W-1:0]    qj_value,
    output logic [DATA_W-1:0]    qk_value,
    output logic                 commit_valid,
    output logic [REG_W-1:0]     commit_rd,
    output logic [DATA_W-1:0]    commit_value,
    output logic [ROB_ADDR-1:0]  commit_robindex,
    output logic                 flush_out,
    output logic [DATA_W-1:0]    flush_pc
);

    localparam int SIZE = 2**ROB_ADDR;
    localparam logic [ROB_ADDR:0] FULL_CNT = (ROB_ADDR+1)'(SIZE);

    logic [SIZE-1:0]              busy, ready, is_branch, pred;
    logic [SIZE-1:0][REG_W-1:0]   rd;
    logic [SIZE-1:0][DATA_W-1:0]  alt_pc, value;
    logic [ROB_ADDR-1:0]          head, tail;
    logic [ROB_ADDR:0]            count;

    logic commit_fire, mispredict, issue_fire, rs_wb, lsb_wb;

    assign rob_full = (count == FULL_CNT);
    assign rob_tail = tail;

    // A full buffer can still accept an issue on the cycle its head retires.
    always_comb begin
        commit_fire = rdy_in && (count != '0) && ready[head];
        mispredict  = commit_fire && is_branch[head] && (value[head][0] != pred[head]);
        issue_fire  = rdy_in && issue_valid && (!rob_full || commit_fire) && !mispredict;
        rs_wb       = rdy_in && rs_valid;
        lsb_wb      = rdy_in && lsb_valid;
    end

    rob_query #(.ROB_ADDR(ROB_ADDR)) u_query_j (
        .idx(qj_idx), .rs_valid(rs_wb), .rs_robindex(rs_robindex), .rs_value(rs_value),
        .lsb_valid(lsb_wb), .lsb_robindex(lsb_robindex), .lsb_value(lsb_value),
        .ready_vec(ready & busy), .value_vec(value), .ready(qj_ready), .value(qj_value)
    );

    rob_query #(.ROB_ADDR(ROB_ADDR)) u_query_k (
        .idx(qk_idx), .rs_valid(rs_wb), .rs_robindex(rs_robindex), .rs_value(rs_value),
        .lsb_valid(lsb_wb), .lsb_robindex(lsb_robindex), .lsb_value(lsb_value),
        .ready_vec(ready & busy), .value_vec(value), .ready(qk_ready), .value(qk_value)
    );

    // Entry storage, pointers and registered commit/flush outputs; a flush
    // overrides every other update made on the same edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy            <= '0;
            ready           <= '0;
            is_branch       <= '0;
            pred            <= '0;
            rd              <= '0;
            alt_pc          <= '0;
            value           <= '0;
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            commit_valid    <= 1'b0;
            commit_rd       <= '0;
            commit_value    <= '0;
            commit_robindex <= '0;
            flush_out       <= 1'b0;
            flush_pc        <= '0;
        end else if (rdy_in) begin
            commit_valid <= commit_fire;
            flush_out    <= mispredict;
            if (commit_fire) begin
                commit_rd       <= is_branch[head] ? '0 : rd[head];
                commit_value    <= value[head];
                commit_robindex <= head;
                busy[head]      <= 1'b0;
                head            <= head + ROB_ADDR'(1);
            end
            if (mispredict)
                flush_pc <= alt_pc[head];
            if (rs_valid) begin
                ready[rs_robindex] <= 1'b1;
                value[rs_robindex] <= rs_value;
            end
            if (lsb_valid) begin
                ready[lsb_robindex] <= 1'b1;
                value[lsb_robindex] <= lsb_value;
            end
            if (issue_fire) begin
                busy[tail]      <= 1'b1;
                ready[tail]     <= 1'b0;
                rd[tail]        <= issue_rd;
                is_branch[tail] <= issue_is_branch;
                pred[tail]      <= issue_pred_tkn;
                alt_pc[tail]    <= issue_alt_pc;
                tail            <= tail + ROB_ADDR'(1);
            end
            count <= count + (ROB_ADDR+1)'(issue_fire) - (ROB_ADDR+1)'(commit_fire);
            if (mispredict) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                ready <= '0;
                busy  <= '0;
            end
        end else begin
            commit_valid <= 1'b0;
            flush_out    <= 1'b0;
        end
    end

endmodule
